// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundles for decode_stage.
// master: the decode stage itself; slave: the surrounding pipeline.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;

    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rd;
    logic [6:0]      id_opcode;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7;
    logic            id_illegal;

    modport master (
        input  if_valid, if_pc, if_instr, id_ready,
        output if_ready, id_valid, id_pc, id_instr, id_rs1_val, id_rs2_val,
               id_imm, id_rd, id_opcode, id_funct3, id_funct7, id_illegal
    );

    modport slave (
        output if_valid, if_pc, if_instr, id_ready,
        input  if_ready, id_valid, id_pc, id_instr, id_rs1_val, id_rs2_val,
               id_imm, id_rd, id_opcode, id_funct3, id_funct7, id_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: holds one instruction, reads the register file, emits a decoded bundle.
// Define WB_BYPASS_EN to forward same-cycle writeback data into the operands.
module decode_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RST_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    output logic [4:0]      addr_rs1_o,
    output logic [4:0]      addr_rs2_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    decode_stage_if.master  bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {EMPTY, READ, HOLD} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] hold1_q, hold1_d, hold2_q, hold2_d;
    logic            accept;
    logic [XLEN-1:0] op1, op2;
    logic [31:0]     imm32;
    logic            illegal;
    logic [4:0]      rd;
    logic            id_valid;

    assign bus.if_ready = rst_n & ~flush_i & ((state_q == EMPTY) | bus.id_ready);
    assign accept       = bus.if_valid & bus.if_ready;
    assign addr_rs1_o   = accept ? bus.if_instr[19:15] : instr_q[19:15];
    assign addr_rs2_o   = accept ? bus.if_instr[24:20] : instr_q[24:20];
    assign id_valid     = (state_q != EMPTY);

`ifdef WB_BYPASS_EN
    // use*_q: the operand was forwarded from writeback in the accept cycle
    logic use1_q, use1_d, use2_q, use2_d;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_en_i, wb_addr_i, wb_data_i};
`endif

    always_comb begin
        op1 = hold1_q;
        op2 = hold2_q;
        if (state_q == READ) begin
`ifdef WB_BYPASS_EN
            if (!use1_q) op1 = rs1_data_i;
            if (!use2_q) op2 = rs2_data_i;
`else
            op1 = rs1_data_i;
            op2 = rs2_data_i;
`endif
        end
        if (state_q == EMPTY || instr_q[19:15] == 5'd0) op1 = '0;
        if (state_q == EMPTY || instr_q[24:20] == 5'd0) op2 = '0;
    end

    // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        hold1_d = (state_q == READ) ? op1 : hold1_q;
        hold2_d = (state_q == READ) ? op2 : hold2_q;
`ifdef WB_BYPASS_EN
        use1_d  = use1_q;
        use2_d  = use2_q;
        if (state_q != EMPTY && wb_en_i && wb_addr_i != 5'd0) begin
            if (wb_addr_i == instr_q[19:15]) hold1_d = wb_data_i;
            if (wb_addr_i == instr_q[24:20]) hold2_d = wb_data_i;
        end
`endif
        case (state_q)
            EMPTY:   if (accept) state_d = READ;
            default: begin
                if (!bus.id_ready) state_d = HOLD;
                else if (accept)   state_d = READ;
                else               state_d = EMPTY;
            end
        endcase
        if (accept) begin
            pc_d    = bus.if_pc;
            instr_d = bus.if_instr;
`ifdef WB_BYPASS_EN
            use1_d  = wb_en_i && wb_addr_i != 5'd0 && wb_addr_i == bus.if_instr[19:15];
            use2_d  = wb_en_i && wb_addr_i != 5'd0 && wb_addr_i == bus.if_instr[24:20];
            if (use1_d) hold1_d = wb_data_i;
            if (use2_d) hold2_d = wb_data_i;
`endif
        end
        if (flush_i) begin
            state_d = EMPTY;
            instr_d = RST_INSTR;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            pc_q    <= '0;
            instr_q <= RST_INSTR;
            hold1_q <= '0;
            hold2_q <= '0;
`ifdef WB_BYPASS_EN
            use1_q  <= 1'b0;
            use2_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            hold1_q <= hold1_d;
            hold2_q <= hold2_d;
`ifdef WB_BYPASS_EN
            use1_q  <= use1_d;
            use2_q  <= use2_d;
`endif
        end
    end

    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        rd      = instr_q[11:7];
        case (instr_q[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
                imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
            OP_STORE: begin
                imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
                rd    = '0;
            end
            OP_BRANCH: begin
                imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                         instr_q[11:8], 1'b0};
                rd    = '0;
            end
            OP_LUI, OP_AUIPC:
                imm32 = {instr_q[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                         instr_q[30:21], 1'b0};
            OP_REG, OP_FENCE:
                imm32 = '0;
            default:
                illegal = 1'b1;
        endcase
        if (instr_q[1:0] != 2'b11) illegal = 1'b1;
    end

    // Decoded fields read as zero whenever no bundle is presented.
    assign bus.id_valid   = id_valid;
    assign bus.id_pc      = pc_q;
    assign bus.id_instr   = instr_q;
    assign bus.id_rs1_val = op1;
    assign bus.id_rs2_val = op2;
    assign bus.id_imm     = id_valid ? XLEN'($signed(imm32)) : '0;
    assign bus.id_rd      = id_valid ? rd : '0;
    assign bus.id_opcode  = id_valid ? instr_q[6:0] : '0;
    assign bus.id_funct3  = id_valid ? instr_q[14:12] : '0;
    assign bus.id_funct7  = id_valid ? instr_q[31:25] : '0;
    assign bus.id_illegal = id_valid & illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: random fetch/execute/writeback traffic against an
// arithmetic RV32I decode model and a behavioural register file.
module tb_decode_stage;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [4:0]  addr_rs1, addr_rs2;
    logic [31:0] rs1_data = '0, rs2_data = '0;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] regs [32];

    int   n_checks = 0;
    int   n_errs   = 0;
    bit   m_valid  = 1'b0;
    bit   m_ready  = 1'b0;
    exp_t exp_q[$];

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32), .RST_INSTR(32'h0000_0013)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .addr_rs1_o (addr_rs1),
        .addr_rs2_o (addr_rs2),
        .rs1_data_i (rs1_data),
        .rs2_data_i (rs2_data),
        .wb_en_i    (wb_en),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Register file: read data appears one cycle after the address; a same-edge write is not seen.
    always @(posedge clk) begin
        rs1_data <= regs[addr_rs1];
        rs2_data <= regs[addr_rs2];
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= $urandom;
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] operand(input logic [4:0] r, input bit we,
                                            input logic [4:0] wa, input logic [31:0] wd);
        if (r == 5'd0) return '0;
        if (BYP && we && wa == r) return wd;
        return regs[r];
    endfunction

    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins, input bit we,
                                   input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        int   v;
        e.pc = pc;  e.instr = ins;  e.opcode = ins[6:0];
        e.f3 = ins[14:12];  e.f7 = ins[31:25];  e.rd = ins[11:7];  e.illegal = 1'b0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: v = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
            7'h23: begin
                v = int'(ins[11:7]) + int'(ins[30:25]) * 32 - (ins[31] ? 2048 : 0);
                e.rd = '0;
            end
            7'h63: begin
                v = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048
                    - (ins[31] ? 4096 : 0);
                e.rd = '0;
            end
            7'h37, 7'h17: v = int'(ins[31:12]) * 4096;
            7'h6F: v = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
                       - (ins[31] ? 1048576 : 0);
            7'h33, 7'h0F: v = 0;
            default: begin
                v = 0;
                e.illegal = 1'b1;
            end
        endcase
        if (ins[1:0] != 2'b11) e.illegal = 1'b1;
        e.imm = 32'(v);
        e.rs1 = operand(ins[19:15], we, wa, wd);
        e.rs2 = operand(ins[24:20], we, wa, wd);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                                  7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 9) == 0) return w;
        w[6:0]   = ops[$urandom_range(0, 10)];
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    // One clock cycle of stimulus; entered and left 1 time unit after a rising edge.
    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                        input bit rdy, input bit fl, input bit we,
                        input logic [4:0] wa, input logic [31:0] wd);
        bit acc;
        if (BYP && m_valid && !rdy) we = 1'b0;
        bus.if_valid = v;  bus.if_pc = pc;  bus.if_instr = ins;
        bus.id_ready = rdy;  flush = fl;
        wb_en = we;  wb_addr = wa;  wb_data = wd;
        m_ready = rst_n && !fl && (!m_valid || rdy);
        acc = v && m_ready;
        if (acc) exp_q.push_back(model(pc, ins, we, wa, wd));
        @(negedge clk);
        if (acc) begin
            check("addr_rs1", 32'(addr_rs1), 32'(ins[19:15]));
            check("addr_rs2", 32'(addr_rs2), 32'(ins[24:20]));
        end
        @(posedge clk);
        m_valid = (!rst_n || fl) ? 1'b0 : (acc ? 1'b1 : (m_valid && !rdy));
        #1;
    endtask

    // Monitor: compares the presented bundle against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("if_ready", 32'(bus.if_ready), 32'(m_ready));
            check("id_valid", 32'(bus.id_valid), 32'(m_valid));
            if (bus.id_valid) begin
                check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    check("id_pc", bus.id_pc, e.pc);
                    check("id_instr", bus.id_instr, e.instr);
                    check("id_rs1_val", bus.id_rs1_val, e.rs1);
                    check("id_rs2_val", bus.id_rs2_val, e.rs2);
                    check("id_imm", bus.id_imm, e.imm);
                    check("id_rd", 32'(bus.id_rd), 32'(e.rd));
                    check("id_opcode", 32'(bus.id_opcode), 32'(e.opcode));
                    check("id_funct3", 32'(bus.id_funct3), 32'(e.f3));
                    check("id_funct7", 32'(bus.id_funct7), 32'(e.f7));
                    check("id_illegal", 32'(bus.id_illegal), 32'(e.illegal));
                    if (bus.id_ready || flush) void'(exp_q.pop_front());
                end
            end
            if (!rst_n) exp_q.delete();
        end
    end

    initial begin
        logic [31:0] pc = 32'h1000;
        rst_n = 1'b0;  flush = 1'b0;
        bus.if_valid = 1'b0;  bus.if_pc = '0;  bus.if_instr = '0;  bus.id_ready = 1'b0;
        wb_en = 1'b0;  wb_addr = '0;  wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_id_valid", 32'(bus.id_valid), 32'd0);
        check("rst_id_instr", bus.id_instr, 32'h0000_0013);
        check("rst_id_pc", bus.id_pc, 32'd0);
        check("rst_id_opcode", 32'(bus.id_opcode), 32'd0);
        check("rst_if_ready", 32'(bus.if_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_if_ready", 32'(bus.if_ready), 32'd1);

        // addi x1,x0,5 at 0x100
        step(1, 32'h100, 32'h0050_0093, 1, 0, 0, 0, 0);
        check("addi_valid", 32'(bus.id_valid), 32'd1);
        check("addi_rd", 32'(bus.id_rd), 32'd1);
        check("addi_imm", bus.id_imm, 32'd5);
        check("addi_rs1", bus.id_rs1_val, 32'd0);
        check("addi_illegal", 32'(bus.id_illegal), 32'd0);

        // back-to-back stream
        for (int i = 0; i < 4; i++) begin
            step(1, pc, rand_instr(), 1, 0, 0, 0, 0);
            pc += 4;
        end

        // hold for 3 cycles while the held rs1 register is rewritten
        step(1, pc, 32'h0072_8313, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, pc + 4, 32'h0000_0033, 0, 0, 1, 5'd5, $urandom);
        step(1, pc + 4, 32'h0000_0033, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);

        // same-cycle writeback to x1 while add x3,x1,x2 is accepted
        step(0, 0, 0, 1, 0, 1, 5'd1, 32'h0000_1111);
        step(1, 32'h180, 32'h0020_81B3, 1, 0, 1, 5'd1, 32'h0000_DEAD);
        check("wb_rs1", bus.id_rs1_val, BYP ? 32'h0000_DEAD : 32'h0000_1111);

        // flush in READ with a fetch pending
        step(1, 32'h200, 32'h0050_0093, 1, 0, 0, 0, 0);
        step(1, 32'h204, 32'h0000_0033, 0, 1, 0, 0, 0);
        check("flush_valid", 32'(bus.id_valid), 32'd0);
        check("flush_instr", bus.id_instr, 32'h0000_0013);
        step(1, 32'h300, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
        check("illegal_all_ones", 32'(bus.id_illegal), 32'd1);
        step(1, 32'h304, 32'hFE00_0EE3, 1, 0, 0, 0, 0);
        check("beq_imm", bus.id_imm, 32'hFFFF_FFFC);

        // random traffic with one mid-stream reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) rst_n = 1'b0;
            step($urandom_range(0, 3) != 0, pc, rand_instr(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            if (i == 200) begin
                rst_n = 1'b1;
                check("midrst_pc", bus.id_pc, 32'd0);
            end
            pc += 4;
        end

        repeat (3) step(0, 0, 0, 1, 0, 0, 0, 0);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
